// File: rtl/free_list_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : free_list_ckpt_ctrl
// Brief    : Branch checkpoint controller for the speculative RENAME free list.
//            Optional FL_CKPT_STATS_EN adds a saturating mispredict counter.
// Revision : 1.0
// ============================================================================
module free_list_ckpt_ctrl #(
  parameter int NUM_CKPT = 4,
  parameter int CKPT_LOG = 2,
  parameter int HEAD_W   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                recoverFlag_i,
  input  logic                ckptReq_i,
  input  logic [HEAD_W-1:0]   freeListHead_i,
  output logic                ckptGrant_o,
  output logic [CKPT_LOG-1:0] ckptTag_o,
  output logic                ckptFull_o,
  input  logic                resolveValid_i,
  input  logic [CKPT_LOG-1:0] resolveTag_i,
  input  logic                mispredict_i,
  output logic [HEAD_W-1:0]   freeListHeadCp_o,
  output logic                flagRecoverEX_o,
  output logic                ctrlVerified_o,
`ifdef FL_CKPT_STATS_EN
  output logic [15:0]         recoverCnt_o,
`endif
  output logic [CKPT_LOG:0]   ckptCount_o
);

  localparam int CNT_W = CKPT_LOG + 1;

  logic [CKPT_LOG-1:0] headPtr;
  logic [CKPT_LOG-1:0] tailPtr;
  logic [CNT_W-1:0]    count;
  logic [NUM_CKPT-1:0] valid;
  logic [NUM_CKPT-1:0] resolved;
  logic [HEAD_W-1:0]   entryHead [NUM_CKPT];

  logic                tagValid;
  logic                mispHit;
  logic                doMisp;
  logic                corrHit;
  logic                retire;
  logic                grant;
  logic                full;
  logic [CKPT_LOG-1:0] mispOffset;
  logic [NUM_CKPT-1:0] squash;
  logic [NUM_CKPT-1:0] validNext;
  logic [NUM_CKPT-1:0] resolvedNext;
  logic [CNT_W-1:0]    countNext;

  assign tagValid   = valid[resolveTag_i];
  assign mispHit    = resolveValid_i & mispredict_i & tagValid;
  assign doMisp     = mispHit & ~recoverFlag_i;
  assign corrHit    = resolveValid_i & ~mispredict_i & tagValid & ~recoverFlag_i;
  assign full       = (count == CNT_W'(NUM_CKPT));
  assign grant      = ckptReq_i & ~stall_i & ~full & ~recoverFlag_i & ~mispHit;
  assign mispOffset = resolveTag_i - headPtr;
  // Head may still retire under a mispredict unless the head itself is squashed.
  assign retire     = valid[headPtr] & resolved[headPtr] & ~recoverFlag_i &
                      ~(doMisp & (headPtr == resolveTag_i));

  // An entry is younger-or-equal to the mispredicted tag when its age from head is no smaller.
  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_squash
    assign squash[i] = doMisp & ((CKPT_LOG'(i) - headPtr) >= mispOffset);
  end

  always_comb begin
    validNext    = valid;
    resolvedNext = resolved;
    if (recoverFlag_i) begin
      validNext    = '0;
      resolvedNext = '0;
    end else begin
      validNext    = validNext & ~squash;
      resolvedNext = resolvedNext & ~squash;
      if (grant) begin
        validNext[tailPtr]    = 1'b1;
        resolvedNext[tailPtr] = 1'b0;
      end
      if (corrHit) begin
        resolvedNext[resolveTag_i] = 1'b1;
      end
      if (retire) begin
        validNext[headPtr]    = 1'b0;
        resolvedNext[headPtr] = 1'b0;
      end
    end
  end

  always_comb begin
    countNext = count + CNT_W'(grant) - CNT_W'(retire);
    if (recoverFlag_i) begin
      countNext = '0;
    end else if (doMisp) begin
      countNext = CNT_W'(mispOffset - CKPT_LOG'(retire));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr          <= '0;
      tailPtr          <= '0;
      count            <= '0;
      valid            <= '0;
      resolved         <= '0;
      freeListHeadCp_o <= '0;
      flagRecoverEX_o  <= 1'b0;
      ctrlVerified_o   <= 1'b0;
    end else begin
      valid           <= validNext;
      resolved        <= resolvedNext;
      count           <= countNext;
      flagRecoverEX_o <= doMisp;
      ctrlVerified_o  <= doMisp;
      if (recoverFlag_i) begin
        headPtr <= '0;
        tailPtr <= '0;
      end else begin
        headPtr <= headPtr + CKPT_LOG'(retire);
        tailPtr <= doMisp ? resolveTag_i : (tailPtr + CKPT_LOG'(grant));
      end
      if (doMisp) begin
        freeListHeadCp_o <= entryHead[resolveTag_i];
      end
    end
  end

  // Stored heads need no reset; an entry is only read while valid.
  always_ff @(posedge clk) begin
    if (grant) begin
      entryHead[tailPtr] <= freeListHead_i;
    end
  end

`ifdef FL_CKPT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recoverCnt_o <= '0;
    end else if (doMisp && (recoverCnt_o != 16'hFFFF)) begin
      recoverCnt_o <= recoverCnt_o + 16'd1;
    end
  end
`endif

  assign ckptGrant_o = grant;
  assign ckptTag_o   = tailPtr;
  assign ckptFull_o  = full;
  assign ckptCount_o = count;

endmodule
`default_nettype wire
